// File: rtl/soc_system_sysid_checker_pkg.sv
// Shared types and constants for the system-ID checker and its helpers.
package soc_system_sysid_pkg;

  localparam int SYSID_TO_W = 16;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ID_REQ  = 3'd1,
    ST_ID_WAIT = 3'd2,
    ST_TS_REQ  = 3'd3,
    ST_TS_WAIT = 3'd4,
    ST_DONE    = 3'd5
  } sysid_chk_state_t;

  // True in the states that are guarded by the timeout counter.
  function automatic logic is_bus_phase(input sysid_chk_state_t s);
    return (s == ST_ID_REQ) || (s == ST_ID_WAIT) ||
           (s == ST_TS_REQ) || (s == ST_TS_WAIT);
  endfunction

endpackage

// File: rtl/soc_system_sysid_checker_if.sv
// Avalon-MM read-only bus between the checker (master) and the sysid slave.
//
// Handshake: a read is accepted in the cycle where avm_read=1 and
// avm_waitrequest=0; address and read stay stable until then. The response
// is the first cycle with avm_readdatavalid=1 after acceptance, and
// avm_readdata is only meaningful in that cycle. One read outstanding at most.
interface soc_system_sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid
  );
endinterface

// File: rtl/soc_system_timeout_counter.sv
// Per-phase watchdog: counts cycles while enabled, restarts on clear, and
// flags expiry in the cycle where the count reaches limit-1.
module soc_system_timeout_counter
  import soc_system_sysid_pkg::*;
#(
  parameter int W = SYSID_TO_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count;

  // Cycle counter; clear takes priority so a new phase always starts at 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Expiry is combinational so the owner can abort in the same cycle.
  always_comb begin
    expired = enable && (count == (limit - {{(W-1){1'b0}}, 1'b1}));
  end

endmodule

// File: rtl/soc_system_sysid_checker.sv
// Reads the system ID and timestamp words from the sysid slave, compares them
// against the expected build values and reports pass/fail/timeout.
module soc_system_sysid_checker
  import soc_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'hACD5_1302,
  parameter logic [31:0] EXPECTED_TS    = 32'h5900_546F,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          AUTO_START     = 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  soc_system_sysid_checker_if.master        avm,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic                              id_ok,
  output logic                              ts_ok,
  output logic                              timeout,
  output logic [31:0]                       id_value,
  output logic [31:0]                       ts_value,
  output sysid_chk_state_t                  dbg_state
);

  localparam logic [SYSID_TO_W-1:0] TO_LIMIT = TIMEOUT_CYCLES[SYSID_TO_W-1:0];

  sysid_chk_state_t state;
  sysid_chk_state_t next_state;
  logic             auto_pending;
  logic             go;
  logic             progress;
  logic             expired;
  logic             to_clear;
  logic             pass_en;

  soc_system_timeout_counter #(.W(SYSID_TO_W)) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (to_clear),
    .enable  (is_bus_phase(state)),
    .limit   (TO_LIMIT),
    .expired (expired)
  );

  // Launch request: external start or the one-shot auto start after reset.
  always_comb begin
    go = start || auto_pending;
  end

  // Progress in the current bus phase: acceptance in REQ, response in WAIT.
  always_comb begin
    progress = 1'b0;
    case (state)
      ST_ID_REQ,  ST_TS_REQ:  progress = !avm.avm_waitrequest;
      ST_ID_WAIT, ST_TS_WAIT: progress = avm.avm_readdatavalid;
      default:                progress = 1'b0;
    endcase
  end

  // Every state change restarts the watchdog for the next phase.
  always_comb begin
    to_clear = (next_state != state);
  end

  // Auto-start token: armed by reset, spent on the first cycle in IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      auto_pending <= (AUTO_START != 0);
    end else if (state == ST_IDLE) begin
      auto_pending <= 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; progress beats a coincident timeout expiry.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (go) next_state = ST_ID_REQ;
      ST_ID_REQ:  if (!avm.avm_waitrequest) next_state = ST_ID_WAIT;
                  else if (expired)         next_state = ST_DONE;
      ST_ID_WAIT: if (avm.avm_readdatavalid) next_state = ST_TS_REQ;
                  else if (expired)          next_state = ST_DONE;
      ST_TS_REQ:  if (!avm.avm_waitrequest) next_state = ST_TS_WAIT;
                  else if (expired)         next_state = ST_DONE;
      ST_TS_WAIT: if (avm.avm_readdatavalid) next_state = ST_DONE;
                  else if (expired)          next_state = ST_DONE;
      ST_DONE:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  // Result registers: cleared at launch, loaded on responses, held afterwards.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_ok    <= 1'b0;
      ts_ok    <= 1'b0;
      timeout  <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
      pass_en  <= 1'b0;
    end else begin
      if (state == ST_IDLE && go) begin
        id_ok    <= 1'b0;
        ts_ok    <= 1'b0;
        timeout  <= 1'b0;
        id_value <= '0;
        ts_value <= '0;
        pass_en  <= 1'b0;
      end
      if (state == ST_ID_WAIT && avm.avm_readdatavalid) begin
        id_value <= avm.avm_readdata;
        id_ok    <= (avm.avm_readdata == EXPECTED_ID);
      end
      if (state == ST_TS_WAIT && avm.avm_readdatavalid) begin
        ts_value <= avm.avm_readdata;
        ts_ok    <= (avm.avm_readdata == EXPECTED_TS);
      end
      if (is_bus_phase(state) && expired && !progress) begin
        timeout <= 1'b1;
      end
      if (next_state == ST_DONE && state != ST_DONE) begin
        pass_en <= 1'b1;
      end
    end
  end

  // Outputs decoded from the state; pass is visible from DONE onwards.
  always_comb begin
    avm.avm_read    = 1'b0;
    avm.avm_address = SYSID_ADDR_ID;
    busy            = (state != ST_IDLE);
    done            = (state == ST_DONE);
    pass            = pass_en && id_ok && ts_ok && !timeout;
    dbg_state       = state;
    case (state)
      ST_ID_REQ: begin
        avm.avm_read    = 1'b1;
        avm.avm_address = SYSID_ADDR_ID;
      end
      ST_TS_REQ: begin
        avm.avm_read    = 1'b1;
        avm.avm_address = SYSID_ADDR_TS;
      end
      default: begin
        avm.avm_read    = 1'b0;
        avm.avm_address = SYSID_ADDR_ID;
      end
    endcase
  end

endmodule
